// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus: single-outstanding valid/ready request channel
// plus a response channel carrying read data and an error flag.
`ifndef DM_OPSLEN
`define DM_OPSLEN 4
`endif

interface dmem_access_ctrl_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic        bus_rsp_err;

    modport master (
        output bus_req_valid, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
    );

    modport slave (
        input  bus_req_valid, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Memory/writeback data access sequencer: one load or store at a time.
// Optional macro DMEM_TIMEOUT_EN bounds REQ+WAIT to TIMEOUT_CYCLES.
`ifndef DM_OPSLEN
`define DM_OPSLEN 4
`endif

module dmem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [`DM_OPSLEN-1:0] rd_op,
    input  logic [`DM_OPSLEN-1:0] wr_op,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  stall,
    output logic                  done,
    output logic [31:0]           rdata,
    output logic                  misalign_exc,
    output logic                  access_fault,
    dmem_access_ctrl_if.master    mem
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        load_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic                  access;
    logic [`DM_OPSLEN-1:0] op;
    logic [2:0]            f3;
    logic                  illegal;
    logic                  misal;
    logic                  expired;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    function automatic logic [3:0] byte_en(input logic [1:0] sz,
                                           input logic [1:0] o);
        case (sz)
            2'b00:   byte_en = 4'b0001 << o;
            2'b01:   byte_en = 4'b0011 << {o[1], 1'b0};
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_repl(input logic [31:0] d,
                                               input logic [1:0]  sz);
        case (sz)
            2'b00:   store_repl = {4{d[7:0]}};
            2'b01:   store_repl = {2{d[15:0]}};
            default: store_repl = d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [2:0]  f,
                                             input logic [1:0]  o);
        logic [31:0] s;
        s = w >> {o, 3'b000};
        case (f)
            3'b000:  load_ext = {{24{s[7]}}, s[7:0]};
            3'b001:  load_ext = {{16{s[15]}}, s[15:0]};
            3'b100:  load_ext = {24'd0, s[7:0]};
            3'b101:  load_ext = {16'd0, s[15:0]};
            default: load_ext = s;
        endcase
    endfunction

    assign access = rd_en | wr_en;
    assign op     = rd_en ? rd_op : wr_op;
    assign f3     = op[2:0];

    // Classify the access presented in IDLE as illegal or misaligned
    always_comb begin
        illegal = (rd_en & wr_en) | op[3];
        if (rd_en) begin
            illegal = illegal | (f3 == 3'b011) | (f3 == 3'b110) |
                      (f3 == 3'b111);
        end else begin
            illegal = illegal | f3[2] | (f3[1:0] == 2'b11);
        end
        misal = ((f3[1:0] == 2'b01) & addr[0]) |
                ((f3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    end

`ifdef DMEM_TIMEOUT_EN
    logic [31:0] cnt;

    assign expired = (cnt == 32'(TIMEOUT_CYCLES - 1));

    // Count cycles spent in REQ+WAIT; idle keeps it at zero for the next entry
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (state == REQ || state == WAIT) begin
            cnt <= cnt + 32'd1;
        end
    end
`else
    assign expired = 1'b0;
`endif

    // Access sequencer: latch request, drive bus, capture response
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            f3_q         <= '0;
            off_q        <= '0;
            load_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            rdata        <= '0;
            misalign_exc <= 1'b0;
            access_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        f3_q    <= f3;
                        off_q   <= addr[1:0];
                        load_q  <= rd_en;
                        we_q    <= ~rd_en;
                        addr_q  <= {addr[31:2], 2'b00};
                        wdata_q <= store_repl(wdata, f3[1:0]);
                        be_q    <= byte_en(f3[1:0], addr[1:0]);
                        if (illegal) begin
                            access_fault <= 1'b1;
                            state        <= DONE;
                        end else if (misal) begin
                            misalign_exc <= 1'b1;
                            state        <= DONE;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (expired) begin
                        access_fault <= 1'b1;
                        state        <= DONE;
                    end else if (mem.bus_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (expired) begin
                        access_fault <= 1'b1;
                        state        <= DONE;
                    end else if (mem.bus_rsp_valid) begin
                        state <= DONE;
                        if (mem.bus_rsp_err) begin
                            access_fault <= 1'b1;
                            rdata        <= '0;
                        end else if (load_q) begin
                            rdata <= load_ext(mem.bus_rsp_rdata, f3_q, off_q);
                        end else begin
                            rdata <= '0;
                        end
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    rdata        <= '0;
                    misalign_exc <= 1'b0;
                    access_fault <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall = ((state == IDLE) & access) | (state == REQ) |
                   (state == WAIT);
    assign done  = (state == DONE);

    assign mem.bus_req_valid = (state == REQ);
    assign mem.bus_we        = we_q;
    assign mem.bus_addr      = addr_q;
    assign mem.bus_wdata     = wdata_q;
    assign mem.bus_be        = be_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed vector table, hand sequences
// for reset/stale-response/timeout, and random accesses vs a model.
`ifndef DM_OPSLEN
`define DM_OPSLEN 4
`endif

module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [`DM_OPSLEN-1:0] rd_op = '0;
    logic [`DM_OPSLEN-1:0] wr_op = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        misalign_exc;
    logic        access_fault;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl_if mem();

    dmem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en        (rd_en),
        .wr_en        (wr_en),
        .rd_op        (rd_op),
        .wr_op        (wr_op),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .done         (done),
        .rdata        (rdata),
        .misalign_exc (misalign_exc),
        .access_fault (access_fault),
        .mem          (mem)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rdy;
        int          rsp;
        logic [31:0] word;
        logic        err;
        int          exp_cyc;
        logic        exp_req;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
        logic [31:0] exp_rd;
        logic        exp_mis;
        logic        exp_flt;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [31:0] rd, wr, op, a, wd, rdy, rsp, word, err,
        input logic [31:0] cyc, req, we, baddr, bwd, be, rdv, mis, flt);
        vec_t v;
        v.rd = rd[0]; v.wr = wr[0]; v.op = op[3:0];
        v.addr = a; v.wdata = wd;
        v.rdy = int'(rdy); v.rsp = int'(rsp);
        v.word = word; v.err = err[0];
        v.exp_cyc = int'(cyc); v.exp_req = req[0]; v.exp_we = we[0];
        v.exp_addr = baddr; v.exp_wd = bwd; v.exp_be = be[3:0];
        v.exp_rd = rdv; v.exp_mis = mis[0]; v.exp_flt = flt[0];
        return v;
    endfunction

    // Reference: expected outcome from the access rules, in plain arithmetic
    function automatic vec_t model(input vec_t v);
        vec_t   e;
        int     sz;
        int     off;
        bit     bad;
        bit [2:0] f;
        longint m;
        longint x;
        e = v;
        f = v.op[2:0];
        bad = (v.rd && v.wr) || v.op[3] ||
              (v.rd ? (f == 3 || f > 5) : (f > 2));
        sz  = 1 << f[1:0];
        off = int'(v.addr % 4);
        e.exp_req = 0; e.exp_we = 0; e.exp_addr = 0; e.exp_wd = 0;
        e.exp_be = 0; e.exp_rd = 0; e.exp_mis = 0; e.exp_flt = 0;
        if (bad) begin
            e.exp_cyc = 1;
            e.exp_flt = 1;
        end else if (off % sz != 0) begin
            e.exp_cyc = 1;
            e.exp_mis = 1;
        end else begin
            e.exp_cyc  = 3 + v.rdy + v.rsp;
            e.exp_req  = 1;
            e.exp_we   = v.wr;
            e.exp_addr = v.addr - 32'(off);
            e.exp_be   = 4'(((1 << sz) - 1) << off);
            if (sz == 1) e.exp_wd = v.wdata[7:0] * 32'h01010101;
            else if (sz == 2) e.exp_wd = v.wdata[15:0] * 32'h00010001;
            else e.exp_wd = v.wdata;
            e.exp_flt = v.err;
            if (v.rd && !v.err) begin
                m = (64'd1 << (8 * sz)) - 1;
                x = ({32'd0, v.word} >> (8 * off)) & m;
                if (!f[2] && sz < 4 && x[8*sz-1]) x = x | ~m;
                e.exp_rd = x[31:0];
            end
        end
        return e;
    endfunction

    // Present one access, act as the bus, and compare the outcome
    task automatic apply(input vec_t v, input string tag);
        bit          acc = 0, rspd = 0, seen = 0, got = 0;
        bit          stable = 1, quiet = 1;
        int          wcnt = 0, since = 0, stalls = 0, k;
        logic [31:0] c_addr = 0, c_wd = 0;
        logic [3:0]  c_be = 0;
        logic        c_we = 0, st_done = 0, mis = 0, flt = 0;
        logic [31:0] rd = 0;
        rd_en = v.rd; wr_en = v.wr;
        rd_op = v.rd ? v.op : ~v.op;
        wr_op = v.wr ? v.op : ~v.op;
        addr = v.addr; wdata = v.wdata;
        for (k = 0; k < 64; k++) begin
            mem.bus_req_ready = 0;
            mem.bus_rsp_valid = 0;
            mem.bus_rsp_err   = 0;
            mem.bus_rsp_rdata = $urandom;
            if (acc && !rspd) begin
                if (since >= v.rsp) begin
                    mem.bus_rsp_valid = 1;
                    mem.bus_rsp_rdata = v.word;
                    mem.bus_rsp_err   = v.err;
                    rspd = 1;
                end
                since++;
            end
            if (mem.bus_req_valid && !acc) begin
                if (!seen) begin
                    c_we = mem.bus_we; c_addr = mem.bus_addr;
                    c_wd = mem.bus_wdata; c_be = mem.bus_be;
                end else if ({c_we, c_addr, c_wd, c_be} !==
                             {mem.bus_we, mem.bus_addr, mem.bus_wdata,
                              mem.bus_be}) begin
                    stable = 0;
                end
                seen = 1;
                if (wcnt >= v.rdy) begin
                    mem.bus_req_ready = 1;
                    acc = 1;
                end else begin
                    mem.bus_rsp_valid = 1;
                    mem.bus_rsp_err   = 1'($urandom);
                end
                wcnt++;
            end
            #1;
            if (done) begin
                got = 1; st_done = stall; rd = rdata;
                mis = misalign_exc; flt = access_fault;
                break;
            end
            if (stall) stalls++;
            if (misalign_exc || access_fault || rdata != 0) quiet = 0;
            @(posedge clk);
            @(negedge clk);
        end
        if (!got) begin
            chk({tag, "_done_bound"}, 0, 1);
        end else begin
            chk({tag, "_cycle"}, k, v.exp_cyc);
            chk({tag, "_stall_cycles"}, stalls, v.exp_cyc);
            chk({tag, "_stall_at_done"}, st_done, 0);
            chk({tag, "_quiet"}, quiet, 1);
            chk({tag, "_req"}, seen, v.exp_req);
            if (v.exp_req) begin
                chk({tag, "_we"}, c_we, v.exp_we);
                chk({tag, "_addr"}, c_addr, v.exp_addr);
                chk({tag, "_wdata"}, c_wd, v.exp_wd);
                chk({tag, "_be"}, c_be, v.exp_be);
                chk({tag, "_stable"}, stable, 1);
            end
            chk({tag, "_rdata"}, rd, v.exp_rd);
            chk({tag, "_misalign"}, mis, v.exp_mis);
            chk({tag, "_fault"}, flt, v.exp_flt);
        end
        @(posedge clk);
        @(negedge clk);
        rd_en = 0; wr_en = 0;
        mem.bus_req_ready = 0; mem.bus_rsp_valid = 0; mem.bus_rsp_err = 0;
        #1;
        chk({tag, "_after_done"},
            {done, stall, misalign_exc, access_fault, rdata != 0}, 0);
    endtask

    // Responses arriving while idle must produce nothing
    task automatic stale_rsp(input string tag);
        bit q = 1;
        mem.bus_rsp_valid = 1;
        mem.bus_rsp_err   = 1;
        mem.bus_rsp_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            if (done || stall || misalign_exc || access_fault ||
                rdata != 0 || mem.bus_req_valid) q = 0;
        end
        mem.bus_rsp_valid = 0;
        mem.bus_rsp_err   = 0;
        chk(tag, q, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        int   r;

        tbl.push_back(mk(1,0,2,'h100,0,0,0,'hDEADBEEF,0,
                         3,1,0,'h100,0,'hF,'hDEADBEEF,0,0));
        tbl.push_back(mk(1,0,0,'h103,0,0,0,'h80FF0000,0,
                         3,1,0,'h100,0,'h8,'hFFFFFF80,0,0));
        tbl.push_back(mk(1,0,4,'h103,0,0,0,'h80FF0000,0,
                         3,1,0,'h100,0,'h8,'h00000080,0,0));
        tbl.push_back(mk(0,1,1,'h0A,'h1234ABCD,3,0,0,0,
                         6,1,1,'h08,'hABCDABCD,'hC,0,0,0));
        tbl.push_back(mk(1,0,2,'h102,0,0,0,0,0, 1,0,0,0,0,0,0,1,0));
        tbl.push_back(mk(1,1,2,'h100,0,0,0,0,0, 1,0,0,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,2,'h104,0,0,0,'h12345678,1,
                         3,1,0,'h104,0,'hF,0,0,1));
        tbl.push_back(mk(1,0,1,'h102,0,1,1,'h80011234,0,
                         5,1,0,'h100,0,'hC,'hFFFF8001,0,0));
        tbl.push_back(mk(1,0,5,'h100,0,0,0,'h0000F00F,0,
                         3,1,0,'h100,0,'h3,'h0000F00F,0,0));
        tbl.push_back(mk(0,1,0,'h101,'hA5,0,2,'hFFFFFFFF,0,
                         5,1,1,'h100,'hA5A5A5A5,'h2,0,0,0));
        tbl.push_back(mk(0,1,2,'h200,'hCAFEF00D,0,0,'h11111111,0,
                         3,1,1,'h200,'hCAFEF00D,'hF,0,0,0));
        tbl.push_back(mk(1,0,3,'h100,0,0,0,0,0, 1,0,0,0,0,0,0,0,1));
        tbl.push_back(mk(0,1,4,'h100,0,0,0,0,0, 1,0,0,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,'hA,'h100,0,0,0,0,0, 1,0,0,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,2,'h300,0,2,3,'h0BADF00D,0,
                         8,1,0,'h300,0,'hF,'h0BADF00D,0,0));
        tbl.push_back(mk(0,1,1,'h103,'h55,0,0,0,0, 1,0,0,0,0,0,0,1,0));
        tbl.push_back(mk(1,0,5,'h101,0,0,0,0,0, 1,0,0,0,0,0,0,1,0));

        mem.bus_req_ready = 0;
        mem.bus_rsp_valid = 0;
        mem.bus_rsp_err   = 0;
        mem.bus_rsp_rdata = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_flags", {stall, done, misalign_exc, access_fault,
                            mem.bus_req_valid, mem.bus_we, mem.bus_be}, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_bus_addr", mem.bus_addr, 0);
        rst = 1;
        @(negedge clk);

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // Reset while waiting for a response, then a late response
        rd_en = 1; rd_op = 4'h2; wr_op = 4'h0;
        addr = 32'h40; wdata = 32'h7777_7777;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rw_req_valid", mem.bus_req_valid, 1);
        mem.bus_req_ready = 1;
        @(posedge clk);
        @(negedge clk);
        mem.bus_req_ready = 0;
        #1;
        chk("rw_wait_stall", {stall, mem.bus_req_valid}, 2'b10);
        rst = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        rd_en = 0;
        #1;
        chk("rw_flags", {stall, done, misalign_exc, access_fault,
                         mem.bus_req_valid, mem.bus_we, mem.bus_be}, 0);
        chk("rw_rdata", rdata, 0);
        chk("rw_bus_addr", mem.bus_addr, 0);
        chk("rw_bus_wdata", mem.bus_wdata, 0);
        stale_rsp("rw_late_rsp");

`ifdef DMEM_TIMEOUT_EN
        apply(mk(1,0,2,'h400,0,0,1000,0,0, 9,1,0,'h400,0,'hF,0,0,1),
              "to_no_rsp");
        stale_rsp("to_late_rsp");
        apply(mk(0,1,2,'h404,'h1,1000,0,0,0, 9,1,1,'h404,'h1,'hF,0,0,1),
              "to_no_ready");
`endif

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 15);
            v.rd    = (r == 0) || (r < 8);
            v.wr    = (r == 0) || (r >= 8);
            v.op    = {($urandom_range(0, 7) == 0),
                       3'($urandom_range(0, 7))};
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.rdy   = $urandom_range(0, 2);
            v.rsp   = $urandom_range(0, 2);
            v.word  = $urandom;
            v.err   = ($urandom_range(0, 7) == 0);
            v = model(v);
            apply(v, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequences data-memory accesses for the memory/writeback stage of the RISC-V pipeline. It takes the load/store controls held in the DE/MW control register (rd_en, wr_en, rd_op, wr_op) plus the address and store data, and drives a single-outstanding valid/ready request/response bus. It stalls the pipeline until the access completes, then returns aligned, extended load data or an exception flag.

Parameters:
TIMEOUT_CYCLES, 64, maximum cycles spent in REQ+WAIT before a forced fault; used only with DMEM_TIMEOUT_EN.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-low reset
rd_en  input  1  load request from MW stage
wr_en  input  1  store request from MW stage
rd_op  input  `DM_OPSLEN  load op; [2:0]=funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU), [3] must be 0
wr_op  input  `DM_OPSLEN  store op; [2:0]=funct3 (000 SB, 001 SH, 010 SW), [3] must be 0
addr  input  32  byte address (ALU result)
wdata  input  32  store data (rs2)
stall  output  1  hold pipeline
done  output  1  one-cycle completion pulse
rdata  output  32  extended load data, valid when done=1
misalign_exc  output  1  misaligned access, valid when done=1
access_fault  output  1  illegal op, bus error or timeout, valid when done=1
bus_req_valid  output  1  request valid
bus_req_ready  input  1  request accepted
bus_we  output  1  1=write
bus_addr  output  32  word-aligned address ({addr[31:2],2'b00})
bus_wdata  output  32  replicated store data
bus_be  output  4  byte enables
bus_rsp_valid  input  1  response valid
bus_rsp_rdata  input  32  read word
bus_rsp_err  input  1  response error

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset (rst=0 at clock edge) -> IDLE; all outputs 0; latched request cleared; any pending bus transaction abandoned.
- IDLE: access = rd_en|wr_en. If access, stall=1 combinationally in the same cycle, and the block latches addr, op, wdata and the kind (load or store).
  - Illegal case: rd_en&wr_en, op[3]=1, or an undefined funct3. Go to DONE with access_fault=1.
  - Misaligned case: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0. Go to DONE with misalign_exc=1. No bus request is issued.
  - Otherwise go to REQ.
- REQ: bus_req_valid=1. bus_we, bus_addr, bus_wdata and bus_be come from registers and stay stable until bus_req_ready=1, then go to WAIT. bus_rsp_valid is ignored in REQ.
- WAIT: on bus_rsp_valid, latch result and go to DONE. If bus_rsp_err=1, access_fault=1 and rdata=0.
- DONE: done=1, stall=0 for exactly one cycle, then unconditional return to IDLE. Inputs are ignored in DONE because the same instruction is still presented that cycle.
- stall = (IDLE & access) | REQ | WAIT.
- Byte enables:
  - SB/LB/LBU: 4'b0001<<addr[1:0]
  - SH/LH/LHU: 4'b0011<<{addr[1],1'b0}
  - SW/LW: 4'b1111
- Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- Load data: the word is shifted right by addr[1:0]*8. LB/LH sign-extend; LBU/LHU zero-extend.
- Error outputs: exactly one of misalign_exc and access_fault may be 1 at a time, and both are 0 whenever done=0. rdata=0 for stores and faults.
- Minimum latency with a zero-wait bus: detect cycle, REQ, WAIT, DONE = done in cycle 3 after the access first appears. Misaligned or illegal access: done in cycle 1.
- A bus_rsp_valid seen in IDLE or DONE (stale or post-reset) is ignored.

Optional Feature:
DMEM_TIMEOUT_EN:
- Defined: a counter clears on entry to REQ and increments in REQ and WAIT. When it reaches TIMEOUT_CYCLES, the block goes to DONE with access_fault=1. A late response after that is ignored.
- Undefined: no counter; REQ and WAIT wait indefinitely.

Test Plan:
- LW addr=0x100, ready and rsp immediate, rsp_rdata=0xDEADBEEF -> bus_be=1111, bus_addr=0x100, stall high for 3 cycles, done in cycle 3, rdata=0xDEADBEEF.
- LB addr=0x103, rsp_rdata=0x80FF_0000 -> bus_be=1000, rdata=0xFFFFFF80. LBU same stimulus -> rdata=0x00000080.
- SH addr=0x0A, wdata=0x1234ABCD with 3-cycle ready delay -> bus_we=1, bus_addr=0x08, bus_be=1100, bus_wdata=0xABCDABCD held stable throughout, done after response.
- LW addr=0x102 -> no bus_req_valid, done in cycle 1 with misalign_exc=1. rd_en=wr_en=1 -> access_fault=1.
- LW with bus_rsp_err=1 -> access_fault=1, rdata=0. rst=0 asserted in WAIT -> next cycle IDLE with all outputs 0, and a later rsp_valid is ignored.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, bus never responds -> done with access_fault=1 exactly 8 cycles after REQ entry.
